// File: rtl/mar_seq_if.sv
// mar_seq_if: command, load-source and status signals of the memory address
// register sequencer. The sequencer takes the slave side; whatever drives
// commands and watches the address takes the master side.
interface mar_seq_if #(
    parameter int AW   = 12,
    parameter int SPW  = 16,
    parameter int ARGW = 10,
    parameter int LENW = 4
);
    logic            load;
    logic            mar_inc;
    logic            jump;
    logic            pc_mar_load;
    logic            mar_a_load;
    logic            mar_stack;
    logic [SPW-1:0]  sp_out;
    logic [ARGW-1:0] ir_arg;
    logic [AW-1:0]   bus;
    logic [AW-1:0]   pc;
    logic [AW-1:0]   a_out;
    logic            burst_start;
    logic [LENW-1:0] burst_len;
    logic            mem_ready;
    logic [AW-1:0]   out;
    logic            busy;
    logic            burst_done;
    logic            wrap;
    logic            stack_fault;

    modport master (
        output load, mar_inc, jump, pc_mar_load, mar_a_load, mar_stack,
        output sp_out, ir_arg, bus, pc, a_out,
        output burst_start, burst_len, mem_ready,
        input  out, busy, burst_done, wrap, stack_fault
    );

    modport slave (
        input  load, mar_inc, jump, pc_mar_load, mar_a_load, mar_stack,
        input  sp_out, ir_arg, bus, pc, a_out,
        input  burst_start, burst_len, mem_ready,
        output out, busy, burst_done, wrap, stack_fault
    );
endinterface

// File: rtl/mar_seq.sv
// mar_seq: memory address register with prioritised single-cycle load
// commands and a counted burst mode. All state moves on the falling edge of
// clk; reset is asynchronous and active-low.
//
// Optional build macro MAR_STACK_BOUND_EN: when defined, a mar_stack whose
// full-width sum exceeds STACK_LIMIT leaves the address untouched and pulses
// stack_fault instead. When undefined, the stack sum is always truncated and
// loaded and stack_fault stays 0.
//
// state | meaning
// IDLE  | accepting one load command per edge
// BURST | stepping the address on each mem_ready beat, commands dropped
// DONE  | one-cycle burst_done pulse, commands dropped
module mar_seq #(
    parameter int            AW          = 12,
    parameter int            SPW         = 16,
    parameter int            ARGW        = 10,
    parameter int            LENW        = 4,
    parameter logic [AW-1:0] STACK_LIMIT = 12'hFFF
) (
    input logic      clk,
    input logic      reset,
    mar_seq_if.slave mif
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LENW-1:0] cnt_q, cnt_d;
    logic            wrap_q, wrap_d;
    logic            fault_q, fault_d;

    logic [AW:0]     inc_sum;
    logic [AW:0]     jump_sum;
    logic [AW-1:0]   stack_addr;

    assign inc_sum  = {1'b0, addr_q} + (AW+1)'(1);
    assign jump_sum = {1'b0, addr_q} + (AW+1)'(2);

`ifdef MAR_STACK_BOUND_EN
    logic [SPW:0] stack_sum;
    logic         stack_over;
    assign stack_sum  = {1'b0, mif.sp_out} + (SPW+1)'(mif.ir_arg) + (SPW+1)'(1);
    assign stack_addr = stack_sum[AW-1:0];
    assign stack_over = stack_sum > (SPW+1)'(STACK_LIMIT);
`else
    // Only the low AW bits survive truncation, so the sum is formed at AW bits.
    assign stack_addr = mif.sp_out[AW-1:0] + AW'(mif.ir_arg) + AW'(1);
`endif

    // Next-state, next-address and pulse decode; commands only act in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mif.burst_start) begin
                    addr_d  = mif.bus;
                    cnt_d   = mif.burst_len;
                    state_d = (mif.burst_len == '0) ? ST_DONE : ST_BURST;
                end else if (mif.mar_stack) begin
`ifdef MAR_STACK_BOUND_EN
                    if (stack_over) begin
                        fault_d = 1'b1;
                    end else begin
                        addr_d = stack_addr;
                    end
`else
                    addr_d = stack_addr;
`endif
                end else if (mif.load) begin
                    addr_d = mif.bus;
                end else if (mif.jump) begin
                    {wrap_d, addr_d} = jump_sum;
                end else if (mif.pc_mar_load) begin
                    addr_d = mif.pc;
                end else if (mif.mar_inc) begin
                    {wrap_d, addr_d} = inc_sum;
                end else if (mif.mar_a_load) begin
                    addr_d = mif.a_out;
                end
            end
            ST_BURST: begin
                if (mif.mem_ready) begin
                    {wrap_d, addr_d} = inc_sum;
                    cnt_d            = cnt_q - LENW'(1);
                    if (cnt_q == LENW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Falling-edge state register; reset aborts any burst without a done pulse.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            fault_q <= fault_d;
        end
    end

    assign mif.out         = addr_q;
    assign mif.busy        = (state_q == ST_BURST);
    assign mif.burst_done  = (state_q == ST_DONE);
    assign mif.wrap        = wrap_q;
    assign mif.stack_fault = fault_q;
endmodule

// File: tb/tb_mar_seq.sv
// tb_mar_seq: directed vectors for mar_seq. Each stimulus step queues the
// hand-computed outputs expected after the next falling edge; a monitor pops
// and compares them shortly after that edge.
module tb_mar_seq;
    localparam int AW   = 12;
    localparam int SPW  = 16;
    localparam int ARGW = 10;
    localparam int LENW = 4;
`ifdef MAR_STACK_BOUND_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    typedef struct {
        string         name;
        logic [AW-1:0] out;
        logic          busy;
        logic          done;
        logic          wrap;
        logic          fault;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mar_seq_if #(.AW(AW), .SPW(SPW), .ARGW(ARGW), .LENW(LENW)) mif ();

    mar_seq #(
        .AW(AW), .SPW(SPW), .ARGW(ARGW), .LENW(LENW),
        .STACK_LIMIT(12'h0FF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mif(mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_cmds();
        mif.load        = 1'b0;
        mif.mar_inc     = 1'b0;
        mif.jump        = 1'b0;
        mif.pc_mar_load = 1'b0;
        mif.mar_a_load  = 1'b0;
        mif.mar_stack   = 1'b0;
        mif.burst_start = 1'b0;
        mif.mem_ready   = 1'b0;
    endtask

    // Queue the expectation for the coming falling edge, then advance to just
    // after the next rising edge and drop the single-cycle commands.
    task automatic tick(input string name, input logic [AW-1:0] e_out,
                        input logic e_busy, input logic e_done,
                        input logic e_wrap, input logic e_fault);
        exp_t e;
        e.name  = name;
        e.out   = e_out;
        e.busy  = e_busy;
        e.done  = e_done;
        e.wrap  = e_wrap;
        e.fault = e_fault;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        clear_cmds();
    endtask

    // Monitor: compare every queued expectation just after its falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (mif.out !== e.out || mif.busy !== e.busy ||
                    mif.burst_done !== e.done || mif.wrap !== e.wrap ||
                    mif.stack_fault !== e.fault) begin
                    errors++;
                    $display("FAIL %s: got out=%h busy=%b done=%b wrap=%b fault=%b, expected out=%h busy=%b done=%b wrap=%b fault=%b",
                             e.name, mif.out, mif.busy, mif.burst_done, mif.wrap,
                             mif.stack_fault, e.out, e.busy, e.done, e.wrap, e.fault);
                end
            end
        end
    end

    initial begin
        reset         = 1'b0;
        mif.sp_out    = '0;
        mif.ir_arg    = '0;
        mif.bus       = '0;
        mif.pc        = '0;
        mif.a_out     = '0;
        mif.burst_len = '0;
        clear_cmds();
        @(posedge clk);
        #1;
        tick("reset_state", 12'h000, 0, 0, 0, 0);

        // increments straight out of reset
        reset = 1'b1;
        mif.mar_inc = 1'b1; tick("inc1", 12'h001, 0, 0, 0, 0);
        mif.mar_inc = 1'b1; tick("inc2", 12'h002, 0, 0, 0, 0);
        mif.mar_inc = 1'b1; tick("inc3", 12'h003, 0, 0, 0, 0);

        // jump wrap
        mif.bus = 12'hFFE; mif.load = 1'b1; tick("load_ffe", 12'hFFE, 0, 0, 0, 0);
        mif.jump = 1'b1;                    tick("jump_wrap", 12'h000, 0, 0, 1, 0);
        tick("wrap_one_cycle", 12'h000, 0, 0, 0, 0);

        // stack loads, stack beats load
        mif.sp_out = 16'h0100; mif.ir_arg = 10'd5; mif.bus = 12'h555;
        mif.mar_stack = 1'b1; mif.load = 1'b1;
        tick("stack_over_load", BOUND ? 12'h000 : 12'h106, 0, 0, 0, BOUND);
        tick("stack_idle1", BOUND ? 12'h000 : 12'h106, 0, 0, 0, 0);
        mif.sp_out = 16'h00F0; mif.ir_arg = 10'h00E; mif.mar_stack = 1'b1;
        tick("stack_at_limit", 12'h0FF, 0, 0, 0, 0);
        mif.sp_out = 16'h00FF; mif.ir_arg = 10'd0; mif.mar_stack = 1'b1;
        tick("stack_past_limit", BOUND ? 12'h0FF : 12'h100, 0, 0, 0, BOUND);
        tick("stack_idle2", BOUND ? 12'h0FF : 12'h100, 0, 0, 0, 0);

        // priority chain
        mif.bus = 12'h200; mif.pc = 12'h300; mif.a_out = 12'h7AB;
        mif.load = 1'b1; mif.jump = 1'b1; mif.mar_inc = 1'b1;
        tick("load_over_jump", 12'h200, 0, 0, 0, 0);
        mif.jump = 1'b1; mif.pc_mar_load = 1'b1; mif.mar_inc = 1'b1;
        tick("jump_over_pc", 12'h202, 0, 0, 0, 0);
        mif.pc_mar_load = 1'b1; mif.mar_inc = 1'b1; mif.mar_a_load = 1'b1;
        tick("pc_over_inc", 12'h300, 0, 0, 0, 0);
        mif.mar_inc = 1'b1; mif.mar_a_load = 1'b1;
        tick("inc_over_a", 12'h301, 0, 0, 0, 0);
        mif.mar_a_load = 1'b1;
        tick("a_load", 12'h7AB, 0, 0, 0, 0);

        // increment wrap
        mif.bus = 12'hFFF; mif.load = 1'b1; tick("load_fff", 12'hFFF, 0, 0, 0, 0);
        mif.mar_inc = 1'b1;                 tick("inc_wrap", 12'h000, 0, 0, 1, 0);

        // burst of 3 with a stalled beat; commands during burst/done dropped
        mif.bus = 12'h020; mif.burst_len = 4'd3; mif.burst_start = 1'b1;
        mif.load = 1'b1; mif.mar_stack = 1'b1;
        tick("burst_start", 12'h020, 1, 0, 0, 0);
        mif.mem_ready = 1'b1; mif.mar_inc = 1'b1;
        tick("beat1", 12'h021, 1, 0, 0, 0);
        mif.bus = 12'h500; mif.burst_start = 1'b1;
        tick("beat_stall", 12'h021, 1, 0, 0, 0);
        mif.mem_ready = 1'b1; tick("beat2", 12'h022, 1, 0, 0, 0);
        mif.mem_ready = 1'b1; mif.load = 1'b1;
        tick("beat3_done", 12'h023, 0, 1, 0, 0);
        mif.burst_len = 4'd2; mif.burst_start = 1'b1; mif.mar_inc = 1'b1;
        tick("done_drops_cmds", 12'h023, 0, 0, 0, 0);
        tick("not_queued", 12'h023, 0, 0, 0, 0);

        // zero-length burst
        mif.bus = 12'h040; mif.burst_len = 4'd0; mif.burst_start = 1'b1;
        tick("burst_len0", 12'h040, 0, 1, 0, 0);
        tick("len0_idle", 12'h040, 0, 0, 0, 0);

        // burst wrapping through address 0
        mif.bus = 12'hFFF; mif.burst_len = 4'd2; mif.burst_start = 1'b1;
        tick("wburst_start", 12'hFFF, 1, 0, 0, 0);
        mif.mem_ready = 1'b1; tick("wburst_wrap", 12'h000, 1, 0, 1, 0);
        mif.mem_ready = 1'b1; tick("wburst_done", 12'h001, 0, 1, 0, 0);
        tick("wburst_idle", 12'h001, 0, 0, 0, 0);

        // reset during a burst
        mif.bus = 12'h080; mif.burst_len = 4'd4; mif.burst_start = 1'b1;
        tick("rburst_start", 12'h080, 1, 0, 0, 0);
        mif.mem_ready = 1'b1; tick("rburst_b1", 12'h081, 1, 0, 0, 0);
        mif.mem_ready = 1'b1; tick("rburst_b2", 12'h082, 1, 0, 0, 0);
        reset = 1'b0; mif.mem_ready = 1'b1;
        tick("rburst_reset", 12'h000, 0, 0, 0, 0);
        reset = 1'b1; tick("post_reset1", 12'h000, 0, 0, 0, 0);
        tick("post_reset2", 12'h000, 0, 0, 0, 0);
        mif.mar_inc = 1'b1; tick("post_reset_inc", 12'h001, 0, 0, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mar_seq.md
MAR_SEQ -- requirements
Module: mar_seq

Interface
REQ-001 The block SHALL have parameter AW, default 12: address register width in bits.
REQ-002 The block SHALL have parameter SPW, default 16: stack pointer input width.
REQ-003 The block SHALL have parameter ARGW, default 10: instruction argument width.
REQ-004 The block SHALL have parameter LENW, default 4: burst length field width.
REQ-005 The block SHALL have parameter STACK_LIMIT, default 12'hFFF: highest legal stack address.
REQ-006 clk  input  1  system clock; all state SHALL update on the falling edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 load, mar_inc, jump, pc_mar_load, mar_a_load, mar_stack  input  1 each  single-cycle load commands.
REQ-009 sp_out  input  SPW  stack pointer; ir_arg  input  ARGW  stack offset.
REQ-010 bus, pc, a_out  input  AW each  load sources.
REQ-011 burst_start  input  1  start burst at address bus with length burst_len.
REQ-012 burst_len  input  LENW  number of burst beats.
REQ-013 mem_ready  input  1  memory accepted the current address.
REQ-014 out  output  AW  current address.
REQ-015 busy  output  1  high in BURST state.
REQ-016 burst_done  output  1  one-cycle completion pulse.
REQ-017 wrap  output  1  one-cycle pulse on address wrap-around.
REQ-018 stack_fault  output  1  one-cycle stack bound violation pulse.

Function
REQ-019 In IDLE, the block SHALL honour exactly one command per edge, in priority order: burst_start > mar_stack > load > jump > pc_mar_load > mar_inc > mar_a_load.
REQ-020 mar_stack SHALL load (sp_out + ir_arg + 1), computed at SPW+1 bits and truncated to AW.
REQ-021 jump SHALL add 2 to out; mar_inc SHALL add 1; both SHALL be modulo 2^AW.
REQ-022 When an addition carries out of AW bits, wrap SHALL pulse for one cycle.
REQ-023 The FSM SHALL have states IDLE, BURST and DONE.
REQ-024 burst_start with burst_len > 0 SHALL load out from bus, set the beat counter to burst_len and enter BURST.
REQ-025 burst_start with burst_len = 0 SHALL load out from bus and go directly to DONE.
REQ-026 In BURST, each edge with mem_ready = 1 SHALL increment out by 1 (with the wrap rule) and decrement the counter; mem_ready = 0 SHALL hold both.
REQ-027 In BURST, when the counter is 1 and mem_ready = 1, the FSM SHALL enter DONE.
REQ-028 DONE SHALL last one cycle with burst_done = 1, then the FSM SHALL return to IDLE.
REQ-029 In BURST and DONE, all load commands and burst_start SHALL be ignored and dropped, not queued.
REQ-030 busy SHALL be high only in BURST.

Reset
REQ-031 While reset = 0, the block SHALL asynchronously force out = 0, counter = 0, state = IDLE, and busy, burst_done, wrap and stack_fault all to 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst with no burst_done pulse.
REQ-033 The first command SHALL be accepted on the first falling edge after reset deasserts.

Configuration
REQ-034 With MAR_STACK_BOUND_EN defined, a mar_stack whose untruncated sum exceeds STACK_LIMIT SHALL leave out unchanged and pulse stack_fault for one cycle.
REQ-035 Without MAR_STACK_BOUND_EN, the stack sum SHALL always be truncated and loaded, and stack_fault SHALL be tied to 0.

Verification
REQ-036 Reset low, then high; pulse mar_inc 3 times -> out = 3, wrap = 0.
REQ-037 out = 12'hFFE; jump -> out = 12'h000 and wrap pulses once.
REQ-038 sp_out = 16'h0100, ir_arg = 5, mar_stack and load both high -> out = 12'h106.
REQ-039 bus = 12'h020, burst_len = 3, burst_start; mem_ready pattern 1,0,1,1 -> out = 021, 021, 022, 023; then burst_done pulses once; mar_inc during the burst is ignored.
REQ-040 Burst of length 4 with reset pulsed low after 2 beats -> out = 0, state IDLE, busy = 0, no burst_done pulse.
REQ-041 With MAR_STACK_BOUND_EN, STACK_LIMIT = 12'h0FF, sp_out = 16'h00FF, ir_arg = 0 -> out unchanged, stack_fault = 1 for one cycle; without the macro -> out = 12'h100.
